// File: rtl/seg_scan_pkg.sv
// Package: seg_scan_pkg
// Shared types, constants and the hex-to-segment decode function for the
// 7-segment scan controller.
//   scan_state_t : scan FSM phase (BLANK gap or DRIVE slot)
//   SEG_OFF      : cathode pattern with every segment and the dp dark
//   hex_to_seg   : 4-bit nibble -> active-low {g,f,e,d,c,b,a}
package seg_scan_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_scan_controller_decoder.sv
// Module: seg_hex_decoder
// Combinational hex nibble to active-low 7-segment pattern.
// Ports:
//   hex  in  4  nibble to display
//   seg  out 7  active-low {g,f,e,d,c,b,a}
module seg_hex_decoder
    import seg_scan_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(hex);

endmodule

// File: rtl/seg_scan_controller.sv
// Module: seg_scan_controller
// Time-multiplexed scan controller for a shared 7-segment bus. Each digit is
// driven for SLOT_CYCLES after a BLANK_CYCLES all-anodes-off gap. New images
// arrive through a valid/ready port into a shadow buffer and are committed to
// the displayed image only at the end of a full scan, so frames never tear.
// Optional feature macro: SEG_SCAN_PWM_EN (anode duty control via brightness).
// Ports:
//   clk         in   1            system clock
//   rst         in   1            asynchronous active-high reset
//   wr_valid    in   1            write request
//   wr_ready    out  1            shadow buffer free
//   wr_data     in   4*SEG_COUNT  hex nibble per digit (digit i = [4i+3:4i])
//   wr_dp       in   SEG_COUNT    decimal point per digit, 1 = lit
//   wr_mask     in   SEG_COUNT    digit enable, 0 = dark
//   brightness  in   4            duty level (SEG_SCAN_PWM_EN only)
//   seg         out  8            active-low cathodes {dp,g,f,e,d,c,b,a}
//   an          out  SEG_COUNT    active-low anodes
//   frame_done  out  1            one-cycle pulse on the last cycle of a scan
module seg_scan_controller
    import seg_scan_pkg::*;
#(
    parameter int SEG_COUNT    = 4,
    parameter int SLOT_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [4*SEG_COUNT-1:0] wr_data,
    input  logic [SEG_COUNT-1:0]   wr_dp,
    input  logic [SEG_COUNT-1:0]   wr_mask,
    input  logic [3:0]             brightness,
    output logic [7:0]             seg,
    output logic [SEG_COUNT-1:0]   an,
    output logic                   frame_done
);

    localparam int MAX_CYCLES = (SLOT_CYCLES > BLANK_CYCLES) ? SLOT_CYCLES : BLANK_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES);
    localparam int IDX_W      = (SEG_COUNT > 1) ? $clog2(SEG_COUNT) : 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
    // One cycle before the commit cycle: lets frame_done come out of a
    // register yet still be high on the commit cycle itself.
    localparam logic [CNT_W-1:0] SLOT_PRE   = CNT_W'(SLOT_CYCLES - 2);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(SEG_COUNT - 1);

    scan_state_t            state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [IDX_W-1:0]       idx_reg;

    logic [4*SEG_COUNT-1:0] shadow_data_reg;
    logic [SEG_COUNT-1:0]   shadow_dp_reg;
    logic [SEG_COUNT-1:0]   shadow_mask_reg;
    logic                   pending_reg;

    logic [4*SEG_COUNT-1:0] active_data_reg;
    logic [SEG_COUNT-1:0]   active_dp_reg;
    logic [SEG_COUNT-1:0]   active_mask_reg;

    logic                   wr_ready_reg;
    logic [SEG_COUNT-1:0]   an_reg;
    logic [7:0]             seg_reg;
    logic                   frame_done_reg;

    logic [3:0]             active_digit [SEG_COUNT];
    logic [SEG_COUNT-1:0]   an_drive;
    logic [3:0]             cur_nibble;
    logic [6:0]             cur_seg7;
    logic                   pwm_on;
    logic                   commit_point;
    logic                   wr_accept;

`ifdef SEG_SCAN_PWM_EN
    // Duty gating uses the low 4 counter bits, so the pattern repeats every
    // 16 cycles inside the DRIVE slot.
    assign pwm_on = (cnt_reg[3:0] < brightness);
`else
    logic brightness_unused;
    assign brightness_unused = ^brightness;
    assign pwm_on = 1'b1;
`endif

    for (genvar gi = 0; gi < SEG_COUNT; gi++) begin : g_digit
        assign active_digit[gi] = active_data_reg[4*gi +: 4];
        // Masked digits keep their anode high even in their own slot.
        assign an_drive[gi] = ~((idx_reg == IDX_W'(gi)) && active_mask_reg[gi] && pwm_on);
    end

    assign cur_nibble = active_digit[idx_reg];

    seg_hex_decoder u_dec (
        .hex (cur_nibble),
        .seg (cur_seg7)
    );

    assign commit_point = (state_reg == DRIVE) && (idx_reg == IDX_LAST) && (cnt_reg == SLOT_LAST);
    assign wr_accept    = wr_valid && wr_ready_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= BLANK;
            cnt_reg         <= '0;
            idx_reg         <= '0;
            shadow_data_reg <= '0;
            shadow_dp_reg   <= '0;
            shadow_mask_reg <= '0;
            pending_reg     <= 1'b0;
            active_data_reg <= '0;
            active_dp_reg   <= '0;
            active_mask_reg <= '0;
            wr_ready_reg    <= 1'b1;
            an_reg          <= '1;
            seg_reg         <= SEG_OFF;
            frame_done_reg  <= 1'b0;
        end else begin
            // Scan sequencing
            case (state_reg)
                BLANK: begin
                    if (cnt_reg == BLANK_LAST) begin
                        state_reg <= DRIVE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    if (cnt_reg == SLOT_LAST) begin
                        state_reg <= BLANK;
                        cnt_reg   <= '0;
                        idx_reg   <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            endcase

            // Shadow/active buffering. While pending, wr_ready is low so no
            // write can land on the commit cycle that consumes the shadow; a
            // write accepted on a commit cycle with nothing pending simply
            // waits for the following frame boundary.
            if (commit_point && pending_reg) begin
                active_data_reg <= shadow_data_reg;
                active_dp_reg   <= shadow_dp_reg;
                active_mask_reg <= shadow_mask_reg;
                pending_reg     <= 1'b0;
                wr_ready_reg    <= 1'b1;
            end else if (wr_accept) begin
                shadow_data_reg <= wr_data;
                shadow_dp_reg   <= wr_dp;
                shadow_mask_reg <= wr_mask;
                pending_reg     <= 1'b1;
                wr_ready_reg    <= 1'b0;
            end

            frame_done_reg <= (state_reg == DRIVE) && (idx_reg == IDX_LAST) && (cnt_reg == SLOT_PRE);

            // Pins follow the current FSM state with one register of delay.
            if (state_reg == DRIVE) begin
                an_reg  <= an_drive;
                seg_reg <= active_mask_reg[idx_reg] ? {~active_dp_reg[idx_reg], cur_seg7} : SEG_OFF;
            end else begin
                an_reg  <= '1;
                seg_reg <= SEG_OFF;
            end
        end
    end

    assign wr_ready   = wr_ready_reg;
    assign an         = an_reg;
    assign seg        = seg_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Testbench: tb_seg_scan_controller
// Directed tests of seg_scan_controller with SEG_COUNT=4, SLOT_CYCLES=16,
// BLANK_CYCLES=2 (72-cycle frames). Frame-relative expectations use k = number
// of cycles after the frame_done cycle (k=0): k=1 still shows the last slot of
// the outgoing image, k=2,3 blank, k=4..19 digit 0, and so on, k=72 is the
// next frame_done.
module tb_seg_scan_controller;

    localparam int N     = 4;
    localparam int S     = 16;
    localparam int B     = 2;
    localparam int FRAME = N * (S + B);

    logic           clk = 1'b0;
    logic           rst;
    logic           wr_valid;
    logic           wr_ready;
    logic [4*N-1:0] wr_data;
    logic [N-1:0]   wr_dp;
    logic [N-1:0]   wr_mask;
    logic [3:0]     brightness;
    logic [7:0]     seg;
    logic [N-1:0]   an;
    logic           frame_done;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  mask;
    } img_t;

    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

`ifdef SEG_SCAN_PWM_EN
    localparam logic [3:0] BR_DEFAULT = 4'hF;
`else
    localparam logic [3:0] BR_DEFAULT = 4'h0;
`endif

    seg_scan_controller #(
        .SEG_COUNT    (N),
        .SLOT_CYCLES  (S),
        .BLANK_CYCLES (B)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_dp      (wr_dp),
        .wr_mask    (wr_mask),
        .brightness (brightness),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Expected anodes at frame offset k (1..72).
    function automatic logic [3:0] exp_an(int k, img_t prev, img_t cur, logic [3:0] br);
        int d, r;
        img_t im;
        logic [3:0] a;
        logic lit;
        a = 4'hF;
        if (k == 1) begin
            d = 3; r = 17; im = prev;
        end else begin
            d = (k - 2) / 18; r = (k - 2) % 18; im = cur;
        end
        lit = 1'b1;
`ifdef SEG_SCAN_PWM_EN
        lit = ((r - 2) < int'(br));
`endif
        if (r >= 2 && im.mask[d] && lit) a[d] = 1'b0;
        return a;
    endfunction

    function automatic logic [7:0] exp_seg(int k, img_t prev, img_t cur);
        int d, r;
        img_t im;
        logic [3:0] nib;
        if (k == 1) begin
            d = 3; r = 17; im = prev;
        end else begin
            d = (k - 2) / 18; r = (k - 2) % 18; im = cur;
        end
        nib = im.data[4*d +: 4];
        if (r >= 2 && im.mask[d]) return {~im.dp[d], HEX[nib]};
        return 8'hFF;
    endfunction

    task automatic wait_fd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drive_write(input img_t im);
        wr_valid = 1'b1;
        wr_data  = im.data;
        wr_dp    = im.dp;
        wr_mask  = im.mask;
    endtask

    img_t img_dark = '{data: 16'h0000, dp: 4'h0, mask: 4'h0};
    img_t img_a    = '{data: 16'h3210, dp: 4'h0, mask: 4'hF};
    img_t img_b    = '{data: 16'hFEDC, dp: 4'hA, mask: 4'hF};
    img_t img_c    = '{data: 16'h48C5, dp: 4'h1, mask: 4'h5};
    img_t img_d    = '{data: 16'h8888, dp: 4'hF, mask: 4'hF};

    task automatic test_reset();
        int fd_cnt, fd_first, fd_second;
        rst = 1'b1;
        wr_valid = 1'b0; wr_data = '0; wr_dp = '0; wr_mask = '0;
        brightness = BR_DEFAULT;
        repeat (3) @(negedge clk);
        checks++;
        if ({an, seg} !== 12'hFFF) begin
            failures++; $display("FAIL reset_pins an=%h seg=%h required an=f seg=ff", an, seg);
        end
        checks++;
        if (wr_ready !== 1'b1 || frame_done !== 1'b0) begin
            failures++; $display("FAIL reset_flags wr_ready=%b frame_done=%b required 1 0", wr_ready, frame_done);
        end
        rst = 1'b0;
        fd_cnt = 0; fd_first = -1; fd_second = -1;
        for (int i = 1; i <= 150; i++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, wr_ready} !== 13'h1FFF) begin
                failures++;
                $display("FAIL idle_dark cyc=%0d an=%h seg=%h wr_ready=%b required f ff 1", i, an, seg, wr_ready);
            end
            if (frame_done === 1'b1) begin
                fd_cnt++;
                if (fd_first < 0) fd_first = i; else if (fd_second < 0) fd_second = i;
            end
        end
        checks++;
        if (fd_first != 71 || fd_second != 71 + FRAME || fd_cnt != 2) begin
            failures++;
            $display("FAIL fd_period first=%0d second=%0d count=%0d required 71 143 2", fd_first, fd_second, fd_cnt);
        end
        $display("test_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_write();
        bit ok;
        logic [3:0] ea;
        logic [7:0] es;
        drive_write(img_a);
        @(negedge clk);
        wr_valid = 1'b0;
        checks++;
        if (wr_ready !== 1'b0) begin
            failures++; $display("FAIL wr_ready_drop got=%b required 0", wr_ready);
        end
        wait_fd(ok);
        checks++;
        if (!ok || wr_ready !== 1'b0) begin
            failures++; $display("FAIL commit_wait found=%b wr_ready=%b required 1 0", ok, wr_ready);
        end
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            ea = exp_an(k, img_dark, img_a, brightness);
            es = exp_seg(k, img_dark, img_a);
            checks++;
            if (an !== ea || seg !== es || wr_ready !== 1'b1 || frame_done !== (k == FRAME)) begin
                failures++;
                $display("FAIL write_frame k=%0d an=%h seg=%h rdy=%b fd=%b required %h %h 1 %b",
                         k, an, seg, wr_ready, frame_done, ea, es, k == FRAME);
            end
        end
        $display("test_write done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_commit_cycle_write();
        logic [3:0] ea;
        logic [7:0] es;
        checks++;
        if (frame_done !== 1'b1 || wr_ready !== 1'b1) begin
            failures++; $display("FAIL at_boundary fd=%b rdy=%b required 1 1", frame_done, wr_ready);
        end
        drive_write(img_b);
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            wr_valid = 1'b0;
            ea = exp_an(k, img_a, img_a, brightness);
            es = exp_seg(k, img_a, img_a);
            checks++;
            if (an !== ea || seg !== es || wr_ready !== 1'b0 || frame_done !== (k == FRAME)) begin
                failures++;
                $display("FAIL old_persists k=%0d an=%h seg=%h rdy=%b fd=%b required %h %h 0 %b",
                         k, an, seg, wr_ready, frame_done, ea, es, k == FRAME);
            end
        end
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            ea = exp_an(k, img_a, img_b, brightness);
            es = exp_seg(k, img_a, img_b);
            checks++;
            if (an !== ea || seg !== es || wr_ready !== 1'b1 || frame_done !== (k == FRAME)) begin
                failures++;
                $display("FAIL new_image k=%0d an=%h seg=%h rdy=%b fd=%b required %h %h 1 %b",
                         k, an, seg, wr_ready, frame_done, ea, es, k == FRAME);
            end
        end
        $display("test_commit_cycle_write done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_mask_dp();
        bit ok;
        bit masked_lit;
        logic [3:0] ea;
        logic [7:0] es;
        @(negedge clk);
        drive_write(img_c);
        @(negedge clk);
        wr_valid = 1'b0;
        wait_fd(ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL mask_wait_fd found=0 required 1");
        end
        masked_lit = 1'b0;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            if (k > 1 && (an[1] === 1'b0 || an[3] === 1'b0)) masked_lit = 1'b1;
            ea = exp_an(k, img_b, img_c, brightness);
            es = exp_seg(k, img_b, img_c);
            checks++;
            if (an !== ea || seg !== es) begin
                failures++;
                $display("FAIL mask_frame k=%0d an=%h seg=%h required %h %h", k, an, seg, ea, es);
            end
            if (k == 10) begin
                checks++;
                if (seg[7] !== 1'b0 || an !== 4'b1110) begin
                    failures++; $display("FAIL dp_digit0 seg7=%b an=%b required 0 1110", seg[7], an);
                end
            end
            if (k == 46) begin
                checks++;
                if (seg[7] !== 1'b1 || an !== 4'b1011) begin
                    failures++; $display("FAIL dp_digit2 seg7=%b an=%b required 1 1011", seg[7], an);
                end
            end
        end
        checks++;
        if (masked_lit) begin
            failures++; $display("FAIL masked_anodes lit=1 required 0");
        end
        $display("test_mask_dp done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_reset_mid_scan();
        drive_write(img_d);
        @(negedge clk);
        wr_valid = 1'b0;
        checks++;
        if (wr_ready !== 1'b0) begin
            failures++; $display("FAIL mid_pending rdy=%b required 0", wr_ready);
        end
        repeat (44) @(negedge clk);
        checks++;
        if (an !== 4'b1011) begin
            failures++; $display("FAIL mid_drive2 an=%b required 1011", an);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({an, seg, wr_ready, frame_done} !== 14'h3FFE) begin
            failures++;
            $display("FAIL async_reset an=%h seg=%h rdy=%b fd=%b required f ff 1 0", an, seg, wr_ready, frame_done);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 150; i++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, wr_ready} !== 13'h1FFF) begin
                failures++;
                $display("FAIL discarded cyc=%0d an=%h seg=%h rdy=%b required f ff 1", i, an, seg, wr_ready);
            end
        end
        $display("test_reset_mid_scan done checks=%0d failures=%0d", checks, failures);
    endtask

`ifdef SEG_SCAN_PWM_EN
    task automatic test_pwm();
        bit ok;
        int low_cnt [4];
        logic [3:0] ea;
        img_t img_e = '{data: 16'h1111, dp: 4'h0, mask: 4'hF};
        brightness = 4'd4;
        drive_write(img_e);
        @(negedge clk);
        wr_valid = 1'b0;
        wait_fd(ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL pwm_wait_fd found=0 required 1");
        end
        for (int d = 0; d < 4; d++) low_cnt[d] = 0;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) if (k > 1 && an[d] === 1'b0) low_cnt[d]++;
            ea = exp_an(k, img_dark, img_e, brightness);
            checks++;
            if (an !== ea) begin
                failures++; $display("FAIL pwm4 k=%0d an=%b required %b", k, an, ea);
            end
        end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (low_cnt[d] != 4) begin
                failures++; $display("FAIL pwm4_count digit=%0d low=%0d required 4", d, low_cnt[d]);
            end
        end
        brightness = 4'd0;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            checks++;
            if (an !== 4'hF) begin
                failures++; $display("FAIL pwm0 k=%0d an=%b required 1111", k, an);
            end
        end
        $display("test_pwm done checks=%0d failures=%0d", checks, failures);
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_commit_cycle_write();
        test_mask_dp();
        test_reset_mid_scan();
`ifdef SEG_SCAN_PWM_EN
        test_pwm();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
